alu_wide_seq: RTL and testbench
===============================

# alu_wide_seq

Multi-cycle sequencer that drives the 8-bit combinational ALU to perform NBYTES-wide add, bitwise, and shift-right operations. It issues one ALU command per clock, chains the shift/carry bit between byte slices, and assembles the wide result. It sits between the controller (start/done handshake) and the ALU's command/operand/carry ports.

## Interface
- NBYTES, 2, operand width in bytes (≥2); wide width W = 8*NBYTES
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  ALU command to apply per byte (000 add, 100 xor, 101 or, 110 and, 111 srl)
- opA, opB  input  W  wide operands, latched on accepted start
- cin  input  1  initial carry (add) / bit shifted into MSB (srl); ignored for bitwise ops
- alu_cmd  output  3  command to ALU
- alu_inA, alu_inB  output  8  byte-slice operands to ALU
- alu_sc_i  output  1  shift/carry into ALU
- alu_rslt  input  8  ALU result (combinational, same cycle)
- alu_sc_o  input  1  ALU shift/carry out
- busy  output  1  high in RUN
- done  output  1  high for exactly one cycle in DONE
- err  output  1  op was illegal; valid with done
- result  output  W  assembled result; holds until next accepted start
- carry_out  output  1  final carry (add) / bit shifted out of LSB (srl); 0 for bitwise ops
- zero  output  1  result == 0
- parity  output  1  XOR reduction of result

## Operation
- ALU contract: add {sc_o,rslt} = A + B + sc_i; srl {rslt,sc_o} = {sc_i,A}; xor/or/and: sc_o = 0, sc_i ignored.
- States: IDLE, RUN, DONE.
- IDLE with start=1 and legal op: latch opA, opB, op; carry reg ← cin for add/srl, 0 otherwise; idx ← 0 (add, bitwise) or NBYTES-1 (srl); clear result; go to RUN.
- IDLE with start=1 and illegal op (001, 010, 011): result ← 0, err ← 1, carry_out ← 0; go directly to DONE. No ALU cycles are issued.
- RUN: alu_cmd = latched op; alu_inA = opA[idx]; alu_inB = opB[idx]; alu_sc_i = carry reg. At each edge: result[idx] ← alu_rslt; carry reg ← alu_sc_o; idx steps +1 (add, bitwise) or −1 (srl). After the last byte (idx NBYTES-1 for add, 0 for srl), go to DONE.
- DONE: done=1 and carry_out = carry reg. Go to IDLE next cycle. start is ignored in DONE.
- Outside RUN: alu_cmd = 000, alu_inA = alu_inB = 0, alu_sc_i = 0.
- start is ignored in RUN and DONE. Operand changes after acceptance have no effect.
- err is cleared on every accepted legal start.
- zero and parity are combinational from the result register.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, result 0, carry_out 0, alu_cmd 000, alu_inA/alu_inB 0, alu_sc_i 0. zero = 1, parity = 0.
- Legal op: start accepted at edge 0; RUN spans cycles 1..NBYTES; done is high in cycle NBYTES+1 (cycle 3 for NBYTES=2); IDLE in cycle NBYTES+2. The earliest next start is accepted at the end of cycle NBYTES+2.
- Illegal op: done and err are high in cycle 1.
- ALU is combinational: each byte's result is captured the same cycle it is issued. There is no ALU wait state.
- Reset asserted in any state returns the block to reset values at the next edge. done is not asserted for the aborted operation, and partial results are discarded.

## Test plan
- NBYTES=2, add, opA=0x12FF, opB=0x0001, cin=0 -> alu_sc_i is 0 then 1; done in cycle 3; result=0x1300, carry_out=0, zero=0.
- Add, opA=0xFFFF, opB=0x0001, cin=0 -> result=0x0000, carry_out=1, zero=1, parity=0.
- srl, opA=0x8001, cin=0 -> result=0x4000, carry_out=1, with MSB byte issued first. Repeat with cin=1 -> result=0xC000, carry_out=1.
- xor, opA=0xA5A5, opB=0xFF00 -> result=0x5AA5, carry_out=0, parity=0. Then and, same operands -> result=0xA500.
- op=001 -> done and err high in cycle 1, result=0, busy never asserted. A following legal add clears err.
- Reset mid-operation and start-while-busy:
  - start add, reassert start during RUN -> the second request is ignored and the original result is produced.
  - Assert reset in cycle 1 of RUN -> next cycle shows IDLE with all outputs at reset values and no done pulse.

Source files
------------

// File: rtl/alu_wide_seq.sv
// alu_wide_seq: drives an external 8-bit combinational ALU one byte slice per
// clock to build an NBYTES-wide add, xor/or/and or logical shift-right.
// Handshake: start is a request that is accepted only in IDLE. done is a single
// cycle pulse that marks the result, carry_out and err outputs as valid. There
// is no backpressure on done.
module alu_wide_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   opA,
  input  logic [8*NBYTES-1:0]   opB,
  input  logic                  cin,
  output logic [2:0]            alu_cmd,
  output logic [7:0]            alu_inA,
  output logic [7:0]            alu_inB,
  output logic                  alu_sc_i,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sc_o,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  zero,
  output logic                  parity,
  output logic [1:0]            state_dbg
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, result_q;
  logic [2:0]      op_q;
  logic            carry_q;
  logic            err_q;
  logic [IW-1:0]   idx_q;
  logic            op_legal;
  logic            last_byte;
  logic [W-1:0]    a_shift, b_shift;

  assign op_legal  = (op == OP_ADD) || (op == OP_XOR) || (op == OP_OR) ||
                     (op == OP_AND) || (op == OP_SRL);
  // srl walks from the MSB byte down so the shifted bit enters from above.
  assign last_byte = (op_q == OP_SRL) ? (idx_q == '0) : (idx_q == LAST_IDX);

  // Byte-slice selection of the latched operands.
  assign a_shift = a_q >> {idx_q, 3'b000};
  assign b_shift = b_q >> {idx_q, 3'b000};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and ALU command outputs.
  always_comb begin
    state_d  = state_q;
    alu_cmd  = 3'b000;
    alu_inA  = 8'h00;
    alu_inB  = 8'h00;
    alu_sc_i = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = op_legal ? RUN : DONE;
      end
      RUN: begin
        alu_cmd  = op_q;
        alu_inA  = a_shift[7:0];
        alu_inB  = b_shift[7:0];
        alu_sc_i = carry_q;
        if (last_byte) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch, byte index, carry chain and result assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'b000;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            result_q <= '0;
            if (op_legal) begin
              a_q     <= opA;
              b_q     <= opB;
              op_q    <= op;
              carry_q <= ((op == OP_ADD) || (op == OP_SRL)) ? cin : 1'b0;
              idx_q   <= (op == OP_SRL) ? LAST_IDX : '0;
              err_q   <= 1'b0;
            end else begin
              carry_q <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          result_q[idx_q*8 +: 8] <= alu_rslt;
          carry_q <= alu_sc_o;
          if (op_q == OP_SRL) idx_q <= idx_q - 1'b1;
          else                idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign result    = result_q;
  // Bitwise ops leave carry_q at 0 since the ALU reports sc_o = 0 for them.
  assign carry_out = carry_q;
  assign zero      = (result_q == '0);
  assign parity    = ^result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: provides the 8-bit ALU, runs a vector table, a few
// hand-written multi-cycle sequences and randomized ops against a wide model.
module tb_alu_wide_seq;

  localparam int NBYTES = 2;
  localparam int W = 8 * NBYTES;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [2:0]     op = 3'b000;
  logic [W-1:0]   op_a = '0, op_b = '0;
  logic           cin = 1'b0;
  logic [2:0]     alu_cmd;
  logic [7:0]     alu_inA, alu_inB, alu_rslt;
  logic           alu_sc_i, alu_sc_o;
  logic           busy, done, err, carry_out, zero, parity;
  logic [W-1:0]   result;
  logic [1:0]     state_dbg;

  alu_wide_seq #(.NBYTES(NBYTES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(op_a), .opB(op_b),
    .cin(cin), .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB),
    .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o),
    .busy(busy), .done(done), .err(err), .result(result),
    .carry_out(carry_out), .zero(zero), .parity(parity), .state_dbg(state_dbg)
  );

  // External 8-bit combinational ALU
  always_comb begin
    alu_rslt = 8'h00;
    alu_sc_o = 1'b0;
    case (alu_cmd)
      3'b000: {alu_sc_o, alu_rslt} = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'h00, alu_sc_i};
      3'b100: alu_rslt = alu_inA ^ alu_inB;
      3'b101: alu_rslt = alu_inA | alu_inB;
      3'b110: alu_rslt = alu_inA & alu_inB;
      3'b111: {alu_rslt, alu_sc_o} = {alu_sc_i, alu_inA};
      default: ;
    endcase
  end

  // Scoreboard counters and expected queue
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wide reference model
  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         er;
  } ref_t;

  function automatic ref_t model(input logic [2:0] o, input logic [W-1:0] a, b, input logic ci);
    ref_t m;
    logic [W:0] sum;
    m.r = '0; m.co = 1'b0; m.er = 1'b0;
    case (o)
      3'b000: begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        m.r = sum[W-1:0];
        m.co = sum[W];
      end
      3'b100: m.r = a ^ b;
      3'b101: m.r = a | b;
      3'b110: m.r = a & b;
      3'b111: begin m.r = {ci, a[W-1:1]}; m.co = a[0]; end
      default: m.er = 1'b1;
    endcase
    return m;
  endfunction

  // Driver: issue one request, follow it to done. Returns in the done cycle.
  logic [7:0] sc_trace;
  logic [7:0] first_a;
  int         lat;
  logic       saw_busy;

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, b, input logic ci);
    @(negedge clk);
    op = o; op_a = a; op_b = b; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
    lat = 0; saw_busy = 1'b0; sc_trace = 8'h00; first_a = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      if (busy) saw_busy = 1'b1;
      if (c < 8) sc_trace[c] = alu_sc_i;
      if (c == 1) first_a = alu_inA;
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
    end
  endtask

  // Full check of a completed op, then step to IDLE and confirm done dropped.
  task automatic check_done(input string name, input logic [2:0] o, input ref_t m);
    check({name, "_latency"}, lat, (m.er ? 1 : NBYTES + 1));
    check({name, "_result"}, result, m.r);
    check({name, "_carry"}, carry_out, m.co);
    check({name, "_err"}, err, m.er);
    check({name, "_zero"}, zero, (m.r == '0));
    check({name, "_parity"}, parity, ^m.r);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, done, 1'b0);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] exp_r;
    logic         exp_co;
    logic         exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    ref_t m;
    ref_t v;
    logic [W-1:0] got;
    logic [2:0] legal_ops[8];

    vecs[0] = '{3'b000, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0, 1'b0};
    vecs[1] = '{3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{3'b111, 16'h8001, 16'h0000, 1'b0, 16'h4000, 1'b1, 1'b0};
    vecs[3] = '{3'b111, 16'h8001, 16'h0000, 1'b1, 16'hC000, 1'b1, 1'b0};
    vecs[4] = '{3'b100, 16'hA5A5, 16'hFF00, 1'b1, 16'h5AA5, 1'b0, 1'b0};
    vecs[5] = '{3'b110, 16'hA5A5, 16'hFF00, 1'b1, 16'hA500, 1'b0, 1'b0};
    vecs[6] = '{3'b101, 16'hA5A5, 16'hFF00, 1'b0, 16'hFFA5, 1'b0, 1'b0};
    vecs[7] = '{3'b001, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{3'b000, 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0};
    vecs[9] = '{3'b011, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_result", result, '0);
    check("rst_carry", carry_out, 1'b0);
    check("rst_alu", {alu_cmd, alu_inA, alu_inB, alu_sc_i}, '0);
    check("rst_zero", zero, 1'b1);
    check("rst_parity", parity, 1'b0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      if (i == 0) begin
        check("add_sc_i_c1", sc_trace[1], 1'b0);
        check("add_sc_i_c2", sc_trace[2], 1'b1);
      end
      if (i == 2) check("srl_msb_first", first_a, 8'h80);
      if (vecs[i].exp_err) check($sformatf("vec%0d_no_busy", i), saw_busy, 1'b0);
      v.r = vecs[i].exp_r; v.co = vecs[i].exp_co; v.er = vecs[i].exp_err;
      check_done($sformatf("vec%0d", i), vecs[i].op, v);
    end

    // Start reasserted while busy is ignored
    @(negedge clk);
    op = 3'b000; op_a = 16'h0102; op_b = 16'h0304; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op = 3'b110; op_a = 16'hFFFF; op_b = 16'h0F0F; start = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_start_latency", lat, NBYTES + 1);
    check("busy_start_result", result, 16'h0406);
    @(posedge clk); #1;
    check("busy_start_done_drop", done, 1'b0);

    // Reset in the first RUN cycle aborts with no done pulse
    @(negedge clk);
    op = 3'b000; op_a = 16'h7777; op_b = 16'h1111; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, '0);
    check("abort_carry", carry_out, 1'b0);
    check("abort_alu", {alu_cmd, alu_inA, alu_inB, alu_sc_i}, '0);
    check("abort_zero_parity", {zero, parity}, 2'b10);
    saw_busy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (done || busy) saw_busy = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_quiet", saw_busy, 1'b0);

    // Randomized ops against the model
    legal_ops = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b111, 3'b010};
    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      logic ci;
      o = legal_ops[$urandom_range(0, 7)];
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      m = model(o, a, b, ci);
      exp_q.push_back(m.r);
      run_op(o, a, b, ci);
      got = exp_q.pop_front();
      check($sformatf("rnd%0d_result", i), result, got);
      check_done($sformatf("rnd%0d", i), o, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
